// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state encoding, round geometry,
// initial hash value and round constants for the datapath, controller and benches.
package sha256_pkg;

    localparam int ROUNDS = 64;
    localparam int IDX_W  = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        ACCUM,
        OUT
    } state_t;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_round_counter.sv
// Round index counter: counts 0..ROUNDS-1 while enabled and wraps to 0 after the last round.
module sha256_round_counter #(
    parameter int ROUNDS = 64,
    parameter int IDX_W  = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             at_last
);

    assign at_last = (idx == IDX_W'(ROUNDS - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            idx <= '0;
        end else if (en) begin
            idx <= at_last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequencing controller for one SHA-256 compression engine.
// Optional completed-block counter on ops_blocks when SHA256_OPS_CNT_EN is defined.
module sha256_round_ctrl #(
    parameter int ROUNDS = sha256_pkg::ROUNDS,
    parameter int IDX_W  = sha256_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blk_valid,
    input  logic             blk_first,
    input  logic             blk_last,
    output logic             blk_ready,
    output logic             ks_rst,
    output logic             w_load,
    output logic             w_shift,
    output logic             hash_init,
    output logic             hash_ld,
    output logic             rnd_en,
    output logic             hash_accum,
    output logic [IDX_W-1:0] round_idx,
    output logic             digest_valid,
    input  logic             digest_ready
`ifdef SHA256_OPS_CNT_EN
    ,
    output logic [31:0]      ops_blocks
`endif
);
    import sha256_pkg::*;

    state_t state;
    state_t state_nxt;
    logic   first_q;
    logic   last_q;
    logic   at_last;
    logic   cnt_clr;
    logic   cnt_en;

    // Counter is held at zero outside ROUND so round_idx reads 0 in every other state.
    assign cnt_clr = rst || (state != ROUND);
    assign cnt_en  = (state == ROUND);

    sha256_round_counter #(
        .ROUNDS(ROUNDS),
        .IDX_W (IDX_W)
    ) u_round_counter (
        .clk    (clk),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .idx    (round_idx),
        .at_last(at_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && blk_valid) begin
                first_q <= blk_first;
                last_q  <= blk_last;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        blk_ready    = 1'b0;
        ks_rst       = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        hash_init    = 1'b0;
        hash_ld      = 1'b0;
        rnd_en       = 1'b0;
        hash_accum   = 1'b0;
        digest_valid = 1'b0;
        case (state)
            IDLE: begin
                blk_ready = !rst;
                ks_rst    = 1'b1;
                if (blk_valid) state_nxt = LOAD;
            end
            LOAD: begin
                w_load    = 1'b1;
                hash_ld   = 1'b1;
                hash_init = first_q;
                ks_rst    = 1'b1;
                state_nxt = ROUND;
            end
            ROUND: begin
                rnd_en  = 1'b1;
                w_shift = 1'b1;
                if (at_last) state_nxt = ACCUM;
            end
            ACCUM: begin
                hash_accum = 1'b1;
                state_nxt  = last_q ? OUT : IDLE;
            end
            OUT: begin
                digest_valid = 1'b1;
                if (digest_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SHA256_OPS_CNT_EN
    // Saturating count of completed blocks; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_blocks <= '0;
        end else if (state == ACCUM && ops_blocks != 32'hFFFF_FFFF) begin
            ops_blocks <= ops_blocks + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: directed block flows plus randomized
// traffic compared against a cycle-offset reference model of the block schedule.
module tb_sha256_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       blk_valid;
    logic       blk_first;
    logic       blk_last;
    logic       blk_ready;
    logic       ks_rst;
    logic       w_load;
    logic       w_shift;
    logic       hash_init;
    logic       hash_ld;
    logic       rnd_en;
    logic       hash_accum;
    logic [5:0] round_idx;
    logic       digest_valid;
    logic       digest_ready;
`ifdef SHA256_OPS_CNT_EN
    logic [31:0] ops_blocks;
`endif

    always #5 clk = ~clk;

    sha256_round_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .blk_valid   (blk_valid),
        .blk_first   (blk_first),
        .blk_last    (blk_last),
        .blk_ready   (blk_ready),
        .ks_rst      (ks_rst),
        .w_load      (w_load),
        .w_shift     (w_shift),
        .hash_init   (hash_init),
        .hash_ld     (hash_ld),
        .rnd_en      (rnd_en),
        .hash_accum  (hash_accum),
        .round_idx   (round_idx),
        .digest_valid(digest_valid),
        .digest_ready(digest_ready)
`ifdef SHA256_OPS_CNT_EN
        ,
        .ops_blocks  (ops_blocks)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: d = cycles elapsed since block acceptance (0 = waiting for a block).
    // d==1 load, 2..65 rounds, 66 accumulate, 67 digest held until taken.
    int          d = 0;
    bit          m_first = 1'b0;
    bit          m_last = 1'b0;
    int          kidx = 0;
    logic [31:0] m_ops = 32'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (d=%0d)", tag, got, exp, d);
        end
    endtask

    task automatic check_outputs();
        bit idle;
        bit rnd;
        idle = (d == 0);
        rnd  = (d >= 2 && d <= 65);
        chk("blk_ready",    blk_ready,    idle && !rst);
        chk("ks_rst",       ks_rst,       idle || d == 1);
        chk("w_load",       w_load,       d == 1);
        chk("hash_ld",      hash_ld,      d == 1);
        chk("hash_init",    hash_init,    d == 1 && m_first);
        chk("rnd_en",       rnd_en,       rnd);
        chk("w_shift",      w_shift,      rnd);
        chk("round_idx",    round_idx,    rnd ? d - 2 : 0);
        chk("hash_accum",   hash_accum,   d == 66);
        chk("digest_valid", digest_valid, d == 67);
        if (rnd_en === 1'b1) begin
            chk("k_iter", sha256_pkg::K[kidx], sha256_pkg::K[round_idx]);
            if (round_idx == 6'd0)  chk("k_first", sha256_pkg::K[kidx], 32'h428a2f98);
            if (round_idx == 6'd63) chk("k_last",  sha256_pkg::K[kidx], 32'hc67178f2);
        end
`ifdef SHA256_OPS_CNT_EN
        chk("ops_blocks", ops_blocks, m_ops);
`endif
    endtask

    task automatic update_model();
        kidx = (ks_rst === 1'b1) ? 0 : (kidx + 1) % 64;
        if (rst) begin
            d     = 0;
            m_ops = 32'd0;
        end else begin
            if (d == 66 && m_ops != 32'hFFFF_FFFF) m_ops = m_ops + 32'd1;
            if (d == 0) begin
                if (blk_valid) begin
                    d       = 1;
                    m_first = blk_first;
                    m_last  = blk_last;
                end
            end else if (d <= 65) begin
                d = d + 1;
            end else if (d == 66) begin
                d = m_last ? 67 : 0;
            end else if (digest_ready) begin
                d = 0;
            end
        end
    endtask

    // Inputs are stable from just after one rising edge to the next, so the model
    // can both check and advance at the falling edge.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int target, input int budget);
        for (int i = 0; i < budget && d != target; i++) tick();
        chk("reach_phase", d, target);
    endtask

    task automatic send_block(input bit first, input bit last);
        blk_valid = 1'b1;
        blk_first = first;
        blk_last  = last;
        tick();
        blk_valid = 1'b0;
        blk_first = 1'b0;
        blk_last  = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        blk_valid    = 1'b0;
        blk_first    = 1'b0;
        blk_last     = 1'b0;
        digest_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        tick();

        // Single-block message with digest back-pressure and ignored block requests.
        send_block(1'b1, 1'b1);
        run_until(67, 80);
        for (int i = 0; i < 10; i++) begin
            blk_valid = i[0];
            blk_first = 1'b1;
            tick();
        end
        blk_valid    = 1'b0;
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
        tick();

        // Two-block message: no digest after the first block.
        send_block(1'b1, 1'b0);
        run_until(0, 80);
        send_block(1'b0, 1'b1);
        run_until(67, 80);
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;

        // Reset in the middle of the rounds (round_idx 30), then a clean block.
        send_block(1'b1, 1'b1);
        run_until(32, 40);
        chk("mid_round_idx", round_idx, 6'd30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        send_block(1'b1, 1'b1);
        run_until(67, 80);
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 499) == 0);
            blk_valid    = $urandom_range(0, 1) == 1;
            blk_first    = $urandom_range(0, 1) == 1;
            blk_last     = $urandom_range(0, 1) == 1;
            digest_ready = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
